// File: rtl/mem_responder_if.sv
// Request/response bundle between the processor memory port and mem_responder.
interface mem_responder_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) ();
   logic              req;
   logic              rw;
   logic [ADDR_W-1:0] addr;
   logic [3:0]        burst_len;
   logic [DATA_W-1:0] wdata;
   logic              ack;
   logic [DATA_W-1:0] rdata;
   logic [2:0]        beat;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      output req, rw, addr, burst_len, wdata,
      input  ack, rdata, beat, busy, done, err
   );

   modport slave (
      input  req, rw, addr, burst_len, wdata,
      output ack, rdata, beat, busy, done, err
   );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: single-word and burst (up to 8 beats) read/write
// against a word-addressed array, with a fixed number of wait states.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for req; request fields captured on acceptance
// S_WAITS | counting wait states before the first beat
// S_BEAT  | one ack per cycle, idx = current beat
// S_DONE  | transaction finished (err if illegal); held until req drops
module mem_responder #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16,
   parameter int WAIT   = 2
) (
   input  logic              clk,
   input  logic              reset,
   mem_responder_if.slave    bus
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WAITS = 2'd1;
   localparam logic [1:0] S_BEAT  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam int         DEPTH   = 1 << ADDR_W;
   localparam logic [3:0] WAIT_M1 = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

   logic [1:0]        state;
   logic              rw_l;
   logic              err_l;
   logic [ADDR_W-1:0] addr_l;
   logic [3:0]        len_l;
   logic [3:0]        wcnt;
   logic [2:0]        idx;
   logic [DATA_W-1:0] rdata_r;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [ADDR_W-1:0] ea_cur;
   logic [ADDR_W-1:0] ea_next;
   logic              last_beat;

   // Addresses wrap naturally at the top of the array through ADDR_W-bit arithmetic.
   assign ea_cur    = addr_l + ADDR_W'(idx);
   assign ea_next   = ea_cur + ADDR_W'(1);
   assign last_beat = ({1'b0, idx} == (len_l - 4'd1));

   // Sequencer; rdata is loaded on the edge that enters each read beat so it
   // lines up with that beat's ack.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         rw_l    <= 1'b0;
         err_l   <= 1'b0;
         addr_l  <= '0;
         len_l   <= 4'd0;
         wcnt    <= 4'd0;
         idx     <= 3'd0;
         rdata_r <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.req) begin
                  rw_l   <= bus.rw;
                  addr_l <= bus.addr;
                  len_l  <= (bus.burst_len == 4'd0) ? 4'd1 : bus.burst_len;
                  idx    <= 3'd0;
                  if (bus.burst_len > 4'd8) begin
                     err_l <= 1'b1;
                     state <= S_DONE;
                  end else if (WAIT == 0) begin
                     state <= S_BEAT;
                     if (!bus.rw) rdata_r <= mem[bus.addr];
                  end else begin
                     wcnt  <= WAIT_M1;
                     state <= S_WAITS;
                  end
               end
            end
            S_WAITS: begin
               if (wcnt == 4'd0) begin
                  state <= S_BEAT;
                  if (!rw_l) rdata_r <= mem[addr_l];
               end else begin
                  wcnt <= wcnt - 4'd1;
               end
            end
            S_BEAT: begin
               if (last_beat) begin
                  state <= S_DONE;
               end else begin
                  idx <= idx + 3'd1;
                  if (!rw_l) rdata_r <= mem[ea_next];
               end
            end
            S_DONE: begin
               if (!bus.req) begin
                  state <= S_IDLE;
                  err_l <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Array write at the edge closing each write beat; contents survive reset.
   always_ff @(posedge clk) begin
      if (state == S_BEAT && rw_l) mem[ea_cur] <= bus.wdata;
   end

   assign bus.ack   = (state == S_BEAT);
   assign bus.busy  = (state != S_IDLE);
   assign bus.done  = (state == S_DONE);
   assign bus.err   = (state == S_DONE) && err_l;
   assign bus.beat  = idx;
   assign bus.rdata = rdata_r;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multi-cycle processor's memory port.
- Accepts single-word and burst read/write requests from the processor's controller/datapath, covering plain LW/SW and LM/SM bursts of up to 8 registers.
- Inserts a programmable number of wait states.
- Runs a level req / pulsed ack / done handshake against a 16-bit word-addressed array.

Parameters:
- ADDR_W, 8, word-address width; array depth is 2^ADDR_W words.
- DATA_W, 16, data word width.
- WAIT, 2, wait cycles between request acceptance and first beat; 0..15.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  level request; held high by requester until done is seen.
- rw  in  1  1 = write, 0 = read; sampled at acceptance.
- addr  in  ADDR_W  start word address; sampled at acceptance.
- burst_len  in  4  beats requested; 0 is treated as 1; 9..15 is illegal.
- wdata  in  DATA_W  write data; must be valid in every cycle ack=1 during a write.
- ack  out  1  registered one-cycle pulse per beat.
- rdata  out  DATA_W  registered read data, valid when ack=1 on a read.
- beat  out  3  index of the current or last beat, 0..7.
- busy  out  1  high from the cycle after acceptance until return to IDLE.
- done  out  1  high while in DONE.
- err  out  1  high while in DONE if the request was illegal.

Behaviour:
- Reset (asynchronous):
  - state=IDLE; ack=0, rdata=0, beat=0, busy=0, done=0, err=0; internal counters cleared.
  - Array contents are not reset and are preserved across reset.
- IDLE:
  - If req=1 at an edge, latch rw, addr, and len = (burst_len==0 ? 1 : burst_len).
  - If burst_len>8, set err_l and go to DONE.
  - Else if WAIT=0, go to BEAT; else go to WAITS with wcnt=WAIT-1.
- WAITS:
  - busy=1, ack=0.
  - Decrement wcnt; when wcnt==0, go to BEAT next edge.
  - Exactly WAIT cycles are spent in WAITS.
- BEAT:
  - One beat per cycle; ack=1 each BEAT cycle; beat = current index i, starting at 0.
  - Effective address = (addr_l + i) mod 2^ADDR_W; bursts wrap at the top of the array.
  - Read: rdata = mem[ea], registered so that it is valid in the same cycle ack=1.
  - Write: mem[ea] <= wdata at the edge ending the ack cycle.
  - After beat len-1, go to DONE; ack falls.
- DONE:
  - busy=1, done=1, err=err_l.
  - Stay until req=0 is sampled, then go to IDLE and clear err_l.
  - A req still high after done therefore never starts a second transaction; the requester must drop req for at least one cycle.
- Latency:
  - Request sampled at edge T; first ack in cycle T+1+WAIT.
  - Last ack in cycle T+WAIT+len.
  - done in cycle T+WAIT+len+1 at the earliest.
- Inputs outside acceptance: rw, addr and burst_len are ignored except at acceptance. Changing them mid-transaction has no effect.
- req dropped mid-transaction (protocol violation): the transaction still completes. DONE exits immediately because req=0.
- Reset mid-burst: the transaction aborts at once. Beats already written stay written; no further writes occur.
- Illegal burst_len: no array access; zero ack pulses; err=1 and done=1 together.
- rdata hold: rdata holds its last value outside read acks.

Test Plan:
- Single read with WAIT=2, after a single write of 0x1234 to addr 0x05 (burst_len=1) → write shows one ack in cycle T+3, then done. Read of 0x05 shows ack in cycle T+3 with rdata=0x1234, beat=0.
- Wrapping burst write, then read back:
  - Burst write of 4 beats at 0xFE with wdata 0xA000..0xA003 → four consecutive acks with beat 0..3; words land at 0xFE, 0xFF, 0x00, 0x01.
  - Burst read of 4 beats at 0xFE → rdata sequence 0xA000, 0xA001, 0xA002, 0xA003.
- burst_len=0, then burst_len=8:
  - burst_len=0 → exactly one ack.
  - burst_len=8 with WAIT=0 → eight acks starting in cycle T+1, beat reaching 7, then done.
- burst_len=10 → zero acks; done=1 and err=1 one cycle after acceptance; err clears after req drops; the array is unchanged.
- req held high for 5 cycles after done → no second ack, state stays DONE. Dropping req for one cycle, then raising it, starts a new transaction.
- Reset asserted during beat 2 of an 8-beat write → all outputs 0 immediately; beats 0..1 written, beat 2 and beyond not written. A subsequent read confirms this.
